// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared types for the RAM-port arbiter: the RAM handshake state reported by
// the memory model, the arbiter FSM states, the default burst length and a
// width helper for index fields that must stay at least one bit wide.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  // RAM handshake state as reported by the memory side.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM: waiting for a request, or running a granted burst.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Words per dcache block transfer (icache always moves one word).
  localparam int WORDS_PER_BLOCK_DEF = 2;

  // $clog2 that never returns 0, so a field for one item is still 1 bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between the cache requesters + RAM model and the
// arbiter.
//   dreq/dwrite/ireq : per-core cache requests (dwrite qualifies dreq)
//   ramstate         : RAM handshake state
//   grant_*          : current owner, its class and burst word index
//   ram_ren/ram_wen  : RAM enables for the owner
//   done/abort       : one-cycle burst completion / owner-drop pulses
// Modports: slave = arbiter side, master = requester/memory side.
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int CPUS            = 2,
  parameter int WORDS_PER_BLOCK = bus_arbiter_pkg::WORDS_PER_BLOCK_DEF
);
  import bus_arbiter_pkg::*;

  localparam int CW = clog2_min1(CPUS);
  localparam int WW = clog2_min1(WORDS_PER_BLOCK);

  logic [CPUS-1:0] dreq;
  logic [CPUS-1:0] dwrite;
  logic [CPUS-1:0] ireq;
  ramstate_t       ramstate;
  logic            grant_valid;
  logic [CW-1:0]   grant_cpu;
  logic            grant_is_data;
  logic [WW-1:0]   grant_word;
  logic            ram_ren;
  logic            ram_wen;
  logic            done;
  logic            abort;

  modport slave (
    input  dreq, dwrite, ireq, ramstate,
    output grant_valid, grant_cpu, grant_is_data, grant_word,
    output ram_ren, ram_wen, done, abort
  );

  modport master (
    output dreq, dwrite, ireq, ramstate,
    input  grant_valid, grant_cpu, grant_is_data, grant_word,
    input  ram_ren, ram_wen, done, abort
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr_pick
// Combinational round-robin picker: finds the first set request bit at or
// after the pointer, wrapping modulo CPUS.
//   req_i : request vector      ptr_i : search start
//   any_o : some bit is set     idx_o : winning index
// -----------------------------------------------------------------------------
module bus_arbiter_rr_pick #(
  parameter int CPUS = 2,
  parameter int CW   = bus_arbiter_pkg::clog2_min1(CPUS)
) (
  input  logic [CPUS-1:0] req_i,
  input  logic [CW-1:0]   ptr_i,
  output logic            any_o,
  output logic [CW-1:0]   idx_o
);

  int cand_s;

  // Scan offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    any_o  = 1'b0;
    idx_o  = '0;
    cand_s = 0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      cand_s = int'(ptr_i) + k;
      if (cand_s >= CPUS) begin
        cand_s = cand_s - CPUS;
      end else begin
        cand_s = cand_s;
      end
      if (req_i[cand_s[CW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand_s[CW-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Owns the single shared RAM port on behalf of 2*CPUS cache requesters.
// Policy: aged (boosted) icache > dcache > icache, round-robin per class.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus_if    : bus_arbiter_if.slave (requests in, grant/enables/pulses out)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int CPUS            = 2,
  parameter int WORDS_PER_BLOCK = bus_arbiter_pkg::WORDS_PER_BLOCK_DEF,
  parameter int AGE_LIMIT       = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  bus_arbiter_if.slave       bus_if
);
  import bus_arbiter_pkg::*;

  localparam int CW = clog2_min1(CPUS);
  localparam int WW = clog2_min1(WORDS_PER_BLOCK);
  localparam int AW = $clog2(AGE_LIMIT + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cpu_q, cpu_d, dptr_q, dptr_d, iptr_q, iptr_d;
  logic          is_data_q, is_data_d, wflag_q, wflag_d;
  logic [WW-1:0] word_q, word_d;
  logic [AW-1:0] age_q [CPUS];
  logic [AW-1:0] age_d [CPUS];

  logic [CPUS-1:0] boost_s;
  logic            boost_any_s, data_any_s, inst_any_s;
  logic [CW-1:0]   boost_idx_s, data_idx_s, inst_idx_s;
  logic            win_s, win_data_s;
  logic [CW-1:0]   win_cpu_s;
  logic            in_xfer_s, owner_req_s, last_word_s, accept_s;

  function automatic logic [CW-1:0] inc_ptr(input logic [CW-1:0] p);
    logic [CW-1:0] r;
    if (int'(p) >= CPUS - 1) begin
      r = '0;
    end else begin
      r = p + 1'b1;
    end
    return r;
  endfunction

  // An icache request is boosted only while still asserted and fully aged.
  always_comb begin
    boost_s = '0;
    for (int c = 0; c < CPUS; c++) begin
      boost_s[c] = bus_if.ireq[c] && (age_q[c] == AW'(AGE_LIMIT));
    end
  end

  bus_arbiter_rr_pick #(.CPUS(CPUS), .CW(CW)) u_pick_boost (
    .req_i(boost_s), .ptr_i(iptr_q), .any_o(boost_any_s), .idx_o(boost_idx_s));
  bus_arbiter_rr_pick #(.CPUS(CPUS), .CW(CW)) u_pick_data (
    .req_i(bus_if.dreq), .ptr_i(dptr_q), .any_o(data_any_s), .idx_o(data_idx_s));
  bus_arbiter_rr_pick #(.CPUS(CPUS), .CW(CW)) u_pick_inst (
    .req_i(bus_if.ireq), .ptr_i(iptr_q), .any_o(inst_any_s), .idx_o(inst_idx_s));

  // Class priority between the three pickers.
  always_comb begin
    win_s      = 1'b0;
    win_data_s = 1'b0;
    win_cpu_s  = '0;
    if (boost_any_s) begin
      win_s     = 1'b1;
      win_cpu_s = boost_idx_s;
    end else if (data_any_s) begin
      win_s      = 1'b1;
      win_data_s = 1'b1;
      win_cpu_s  = data_idx_s;
    end else if (inst_any_s) begin
      win_s     = 1'b1;
      win_cpu_s = inst_idx_s;
    end else begin
      win_s = 1'b0;
    end
  end

  assign in_xfer_s   = (state_q == XFER);
  assign owner_req_s = is_data_q ? bus_if.dreq[cpu_q] : bus_if.ireq[cpu_q];
  assign last_word_s = is_data_q ? (word_q == WW'(WORDS_PER_BLOCK - 1)) : (word_q == '0);
  assign accept_s    = in_xfer_s && owner_req_s && (bus_if.ramstate == ACCESS);

  // Abort and the RAM enables are gated by the live owner request so a drop
  // is seen (and the RAM released) in the same cycle.
  assign bus_if.grant_valid   = in_xfer_s;
  assign bus_if.grant_cpu     = cpu_q;
  assign bus_if.grant_is_data = is_data_q;
  assign bus_if.grant_word    = word_q;
  assign bus_if.ram_ren       = in_xfer_s && owner_req_s && !wflag_q;
  assign bus_if.ram_wen       = in_xfer_s && owner_req_s && wflag_q;
  assign bus_if.abort         = in_xfer_s && !owner_req_s;
  assign bus_if.done          = accept_s && last_word_s;

  // FSM next state: grant in IDLE, count accepted words in XFER.
  always_comb begin
    state_d   = state_q;
    cpu_d     = cpu_q;
    is_data_d = is_data_q;
    wflag_d   = wflag_q;
    word_d    = word_q;
    dptr_d    = dptr_q;
    iptr_d    = iptr_q;
    case (state_q)
      IDLE: begin
        if (win_s) begin
          state_d   = XFER;
          cpu_d     = win_cpu_s;
          is_data_d = win_data_s;
          wflag_d   = win_data_s && bus_if.dwrite[win_cpu_s];
          word_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!owner_req_s) begin
          state_d = IDLE;
          word_d  = '0;
        end else if (accept_s) begin
          if (last_word_s) begin
            state_d = IDLE;
            word_d  = '0;
            if (is_data_q) begin
              dptr_d = inc_ptr(cpu_q);
            end else begin
              iptr_d = inc_ptr(cpu_q);
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
      end
    endcase
  end

  // Icache ageing: count while waiting, freeze while owning, clear on grant/drop.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      age_d[c] = age_q[c];
      if (!bus_if.ireq[c]) begin
        age_d[c] = '0;
      end else if (!in_xfer_s && win_s && !win_data_s && (win_cpu_s == CW'(c))) begin
        age_d[c] = '0;
      end else if (in_xfer_s && !is_data_q && (cpu_q == CW'(c))) begin
        age_d[c] = age_q[c];
      end else if (age_q[c] != AW'(AGE_LIMIT)) begin
        age_d[c] = age_q[c] + 1'b1;
      end else begin
        age_d[c] = age_q[c];
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cpu_q     <= '0;
      is_data_q <= 1'b0;
      wflag_q   <= 1'b0;
      word_q    <= '0;
      dptr_q    <= '0;
      iptr_q    <= '0;
      for (int c = 0; c < CPUS; c++) begin
        age_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cpu_q     <= cpu_d;
      is_data_q <= is_data_d;
      wflag_q   <= wflag_d;
      word_q    <= word_d;
      dptr_q    <= dptr_d;
      iptr_q    <= iptr_d;
      for (int c = 0; c < CPUS; c++) begin
        age_q[c] <= age_d[c];
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench: a table of cycle vectors, directed multi-cycle
// sequences and randomized traffic, all compared against a behavioural
// model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int CPUS = 2;
  localparam int WPB  = 2;
  localparam int AGE  = 8;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  bus_arbiter_if #(.CPUS(CPUS), .WORDS_PER_BLOCK(WPB)) bus ();

  bus_arbiter #(.CPUS(CPUS), .WORDS_PER_BLOCK(WPB), .AGE_LIMIT(AGE)) dut (
    .CLK(CLK), .nRST(nRST), .bus_if(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_busy, m_data, m_wflag;
  int m_cpu, m_word, m_dptr, m_iptr;
  int m_age [CPUS];
  // model expectations
  bit e_valid, e_data, e_ren, e_wen, e_done, e_abort;
  int e_cpu, e_word;
  // DUT snapshot
  logic s_valid, s_data, s_ren, s_wen, s_done, s_abort;
  logic [0:0] s_cpu, s_word;

  typedef struct {
    logic [1:0] d, dw, i, rs;
    logic v, cpu, data, word, ren, wen, done, abort;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr(input logic [1:0] req, input int ptr);
    for (int k = 0; k < CPUS; k++) begin
      if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_data = 0; m_wflag = 0; m_cpu = 0; m_word = 0;
    m_dptr = 0; m_iptr = 0;
    for (int c = 0; c < CPUS; c++) m_age[c] = 0;
  endtask

  task automatic model_eval(input logic [1:0] d, input logic [1:0] i, input logic [1:0] rs);
    bit own;
    own     = m_busy && (m_data ? d[m_cpu] : i[m_cpu]);
    e_valid = m_busy; e_cpu = m_cpu; e_data = m_data; e_word = m_word;
    e_abort = m_busy && !own;
    e_ren   = own && !m_wflag;
    e_wen   = own && m_wflag;
    e_done  = own && (rs == 2'd2) && (m_word == (m_data ? WPB - 1 : 0));
  endtask

  task automatic model_advance(input logic [1:0] d, input logic [1:0] dw,
                               input logic [1:0] i, input logic [1:0] rs);
    logic [1:0] boosted;
    int w;
    bit own;
    if (!m_busy) begin
      for (int c = 0; c < CPUS; c++) boosted[c] = i[c] && (m_age[c] == AGE);
      w = rr(boosted, m_iptr);
      if (w >= 0) begin m_busy = 1; m_data = 0; m_cpu = w; m_wflag = 0; end
      else begin
        w = rr(d, m_dptr);
        if (w >= 0) begin m_busy = 1; m_data = 1; m_cpu = w; m_wflag = dw[w]; end
        else begin
          w = rr(i, m_iptr);
          if (w >= 0) begin m_busy = 1; m_data = 0; m_cpu = w; m_wflag = 0; end
        end
      end
      for (int c = 0; c < CPUS; c++) begin
        if (!i[c] || (m_busy && !m_data && m_cpu == c)) m_age[c] = 0;
        else m_age[c] = (m_age[c] + 1 > AGE) ? AGE : m_age[c] + 1;
      end
      m_word = 0;
    end else begin
      for (int c = 0; c < CPUS; c++) begin
        if (!i[c]) m_age[c] = 0;
        else if (!(m_data == 0 && m_cpu == c))
          m_age[c] = (m_age[c] + 1 > AGE) ? AGE : m_age[c] + 1;
      end
      own = m_data ? d[m_cpu] : i[m_cpu];
      if (!own) begin
        m_busy = 0; m_word = 0;
      end else if (rs == 2'd2) begin
        if (m_word == (m_data ? WPB - 1 : 0)) begin
          m_busy = 0; m_word = 0;
          if (m_data) m_dptr = (m_cpu + 1) % CPUS;
          else        m_iptr = (m_cpu + 1) % CPUS;
        end else begin
          m_word++;
        end
      end
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, compare with the model, advance.
  task automatic step(input logic [1:0] d, input logic [1:0] dw,
                      input logic [1:0] i, input logic [1:0] rs);
    bus.dreq = d; bus.dwrite = dw; bus.ireq = i; bus.ramstate = ramstate_t'(rs);
    @(negedge CLK);
    s_valid = bus.grant_valid; s_cpu = bus.grant_cpu; s_data = bus.grant_is_data;
    s_word  = bus.grant_word;  s_ren = bus.ram_ren;   s_wen  = bus.ram_wen;
    s_done  = bus.done;        s_abort = bus.abort;
    model_eval(d, i, rs);
    check("grant_valid", s_valid, e_valid);
    check("ram_ren", s_ren, e_ren);
    check("ram_wen", s_wen, e_wen);
    check("done", s_done, e_done);
    check("abort", s_abort, e_abort);
    check("done_abort_excl", s_done & s_abort, 0);
    if (e_valid) begin
      check("grant_cpu", s_cpu, e_cpu);
      check("grant_is_data", s_data, e_data);
      check("grant_word", s_word, e_word);
    end
    model_advance(d, dw, i, rs);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.dreq = '0; bus.dwrite = '0; bus.ireq = '0; bus.ramstate = FREE;
    model_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.grant_valid, 0);
    check({tag, "_cpu"}, bus.grant_cpu, 0);
    check({tag, "_is_data"}, bus.grant_is_data, 0);
    check({tag, "_word"}, bus.grant_word, 0);
    check({tag, "_ren"}, bus.ram_ren, 0);
    check({tag, "_wen"}, bus.ram_wen, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_abort"}, bus.abort, 0);
  endtask

  initial begin
    logic [1:0] d, i, dw;
    int exp_seq [3];

    // single writeback burst, then a read burst with BUSY/ERROR stalls
    //          d      dw     i      rs     v     cpu   data  word  ren   wen   done  abort
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 2'b00, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 2'b00, 2'b00, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b01, 2'b00, 2'b00, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b01, 2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b01, 2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    nRST = 1'b0;
    bus.dreq = '0; bus.dwrite = '0; bus.ireq = '0; bus.ramstate = FREE;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    nRST = 1'b1;

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].d, tbl[k].dw, tbl[k].i, tbl[k].rs);
      check("tbl_valid", s_valid, tbl[k].v);
      check("tbl_ren", s_ren, tbl[k].ren);
      check("tbl_wen", s_wen, tbl[k].wen);
      check("tbl_done", s_done, tbl[k].done);
      check("tbl_abort", s_abort, tbl[k].abort);
      if (tbl[k].v) begin
        check("tbl_cpu", s_cpu, tbl[k].cpu);
        check("tbl_is_data", s_data, tbl[k].data);
        check("tbl_word", s_word, tbl[k].word);
      end
    end

    // both dcaches held: grants alternate 0,1,0
    do_reset();
    exp_seq = '{0, 1, 0};
    for (int cyc = 0; cyc < 9; cyc++) begin
      step(2'b11, 2'b00, 2'b00, 2'd2);
      if (cyc % 3 == 1) begin
        check("rr_valid", s_valid, 1);
        check("rr_cpu", s_cpu, exp_seq[cyc / 3]);
      end
    end

    // icache0 starves behind dcache1 until boosted, then its age clears
    do_reset();
    for (int cyc = 0; cyc < 13; cyc++) begin
      step(2'b10, 2'b00, 2'b01, 2'd2);
      if (cyc == 9) check("boost_idle", s_valid, 0);
      if (cyc == 10) begin
        check("boost_valid", s_valid, 1);
        check("boost_is_data", s_data, 0);
        check("boost_cpu", s_cpu, 0);
      end
      if (cyc == 12) begin
        check("after_boost_is_data", s_data, 1);
        check("after_boost_cpu", s_cpu, 1);
      end
    end

    // abort leaves the data pointer where it was
    do_reset();
    repeat (3) step(2'b01, 2'b00, 2'b00, 2'd2);
    step(2'b10, 2'b00, 2'b00, 2'd2);
    step(2'b10, 2'b00, 2'b00, 2'd2);
    check("abort_pre_cpu", s_cpu, 1);
    check("abort_pre_valid", s_valid, 1);
    step(2'b00, 2'b00, 2'b00, 2'd2);
    check("abort_pulse", s_abort, 1);
    check("abort_no_done", s_done, 0);
    check("abort_no_ren", s_ren, 0);
    step(2'b11, 2'b00, 2'b00, 2'd0);
    step(2'b11, 2'b00, 2'b00, 2'd0);
    check("abort_ptr_cpu", s_cpu, 1);

    // asynchronous reset in the middle of a burst
    do_reset();
    step(2'b01, 2'b00, 2'b00, 2'd2);
    step(2'b01, 2'b00, 2'b00, 2'd2);
    check("pre_reset_word", bus.grant_word, 1);
    #2 nRST = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    bus.dreq = 2'b10;
    @(posedge CLK); #1;
    nRST = 1'b1;
    step(2'b10, 2'b00, 2'b00, 2'd2);
    step(2'b10, 2'b00, 2'b00, 2'd2);
    check("post_rst_valid", s_valid, 1);
    check("post_rst_cpu", s_cpu, 1);
    check("post_rst_word", s_word, 0);

    // random sticky traffic against the model
    do_reset();
    d = '0; i = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(7) == 0) d[c] = ~d[c];
        if ($urandom_range(7) == 0) i[c] = ~i[c];
      end
      dw = 2'($urandom_range(3));
      step(d, dw, i, 2'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequences ownership of the single shared RAM port among all cache requesters (one icache and one dcache per core).
- Grants one requester at a time and counts the words of its burst against ramstate.
- Sits in front of memory_control's datapath muxing: memory_control steers ramaddr/ramstore/load/wait using grant_cpu/grant_is_data, and this block drives ramREN/ramWEN.
- Policy: data over instruction, round-robin within each class, aging to prevent icache starvation.

Parameters:
CPUS, 2, number of cores (requesters = 2*CPUS)
WORDS_PER_BLOCK, 2, words per dcache block transfer (icache transfers 1 word)
AGE_LIMIT, 8, cycles an icache request may wait before it is boosted above data class

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
dreq  in  CPUS  dcache bus request, held until done/abort
dwrite  in  CPUS  qualifies dreq: 1 = writeback, 0 = block fill; sampled at grant
ireq  in  CPUS  icache fetch request, held until done/abort
ramstate  in  2  ramstate_t from cpu_types_pkg (FREE, BUSY, ACCESS, ERROR)
grant_valid  out  1  a transfer is owned
grant_cpu  out  $clog2(CPUS) (min 1)  owning core
grant_is_data  out  1  1 = dcache owns, 0 = icache owns
grant_word  out  $clog2(WORDS_PER_BLOCK) (min 1)  current word index of burst
ram_ren  out  1  RAM read enable
ram_wen  out  1  RAM write enable
done  out  1  one-cycle pulse: last word accepted
abort  out  1  one-cycle pulse: owner dropped request mid-burst

Behaviour:
- Reset (async, immediate, also mid-burst):
  - state=IDLE; all outputs 0.
  - Both round-robin pointers = 0; all age counters = 0; latched write flag = 0.
- States: IDLE, XFER.
- IDLE arbitration (combinational on current requests); winner registered, next state XFER. grant_valid asserts the cycle after the request is first seen (1-cycle latency).
  - Priority 1: any icache requester with age == AGE_LIMIT (boosted); round-robin among them from the icache pointer.
  - Priority 2: any dreq; round-robin from the data pointer.
  - Priority 3: any ireq; round-robin from the icache pointer.
  - No request: stay IDLE.
- Round-robin: search starts at pointer, wraps modulo CPUS. On done, that class's pointer = (grant_cpu+1) mod CPUS. On abort, the pointer is unchanged.
- Age counters, one per core:
  - Increment each cycle ireq[c]=1 and icache c is not the current owner; saturate at AGE_LIMIT.
  - Clear when ireq[c]=0 or when icache c is granted.
- XFER:
  - grant_valid=1.
  - ram_ren = ~wflag; ram_wen = wflag, where wflag = dwrite[grant_cpu] latched at grant (0 for icache).
  - On ramstate==ACCESS, the word is accepted and grant_word increments.
  - FREE/BUSY: hold. ERROR: hold the same word (retry), no increment.
  - Last word: icache word 0; dcache word WORDS_PER_BLOCK-1.
  - On ACCESS of the last word: done=1 that cycle (combinational); next state IDLE with grant_word=0.
  - The next grant cannot appear before the cycle after IDLE (one dead cycle between bursts).
- Abort: in XFER, if the owner's request bit (dreq or ireq per grant_is_data) is 0:
  - abort=1 and ram_ren=ram_wen=0 that cycle.
  - next state IDLE, grant_word cleared.
  - Abort takes precedence over a coincident ACCESS; done is not pulsed.
- Simultaneous events:
  - New requests during XFER are not registered, only observed (no queue beyond the held request lines).
  - dwrite changes mid-burst are ignored.
  - done and abort are never both 1.

Decomposition:
- Add to cpu_types_pkg (shared): arb_state_t enum {IDLE, XFER} and the WORDS_PER_BLOCK default constant. ramstate_t is already there.
- Sub-module rr_pick: parameterized CPUS-wide round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: any, index.
  - Instantiated twice (data, icache), plus a third time on the boosted vector.

Test Plan:
1. dreq=01, dwrite=01, ramstate ACCESS every cycle → grant_valid at cycle 1 with grant_cpu=0, grant_is_data=1, ram_wen=1; grant_word 0 then 1; done at cycle 2; IDLE at cycle 3.
2. dreq=11 held through repeated bursts, ramstate=ACCESS → grants alternate cpu0, cpu1, cpu0; data pointer advances after each done.
3. ireq=01 and dreq=10 held continuously, RAM always ACCESS → icache0 ages to 8, is boosted, wins the next IDLE arbitration with grant_is_data=0; age counter clears.
4. dreq=01, ramstate BUSY, BUSY, ERROR, ACCESS, ACCESS → grant_word stays 0 through ERROR; done on 5th XFER cycle only.
5. Grant to dcache1, then dreq[1] dropped in 2nd XFER cycle while ramstate=ACCESS → abort=1, done=0, ram_ren=0; data pointer unchanged (cpu1 wins again if re-requesting alone).
6. nRST asserted mid-XFER (grant_word=1) → all outputs 0 immediately; after release with dreq=10, grant_cpu=1, grant_word=0.
